// File: rtl/ram_1r1w.sv
// Simple dual-port RAM with one write port, one registered read port and one clock.
// Holds per-loop strides and running offsets for the memory walker.
module ram_1r1w #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic                  s_write_req,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    input  logic                  s_read_req,
    output logic [DATA_WIDTH-1:0] s_read_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (s_write_req) begin
            mem[s_write_addr] <= s_write_data;
        end
    end

    // Non-blocking read of mem gives read-first on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_read_data <= '0;
        end else if (s_read_req) begin
            s_read_data <= mem[s_read_addr];
        end
    end

endmodule

// File: tb/tb_ram_1r1w.sv
// Self-checking bench for ram_1r1w.
// Reads push expected words to a queue; each test pops and compares after the edge.
module tb_ram_1r1w;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] s_write_addr;
    logic          s_write_req;
    logic [DW-1:0] s_write_data;
    logic [AW-1:0] s_read_addr;
    logic          s_read_req;
    logic [DW-1:0] s_read_data;

    int n_cmp;
    int n_err;

    logic [DW-1:0] model [int];
    logic [DW-1:0] exp_q [$];

    ram_1r1w #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_write_addr(s_write_addr),
        .s_write_req (s_write_req),
        .s_write_data(s_write_data),
        .s_read_addr (s_read_addr),
        .s_read_req  (s_read_req),
        .s_read_data (s_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // One clock: drive, take the edge, settle. Read expectation uses the
    // model before the same-cycle write lands, i.e. read-first.
    task automatic step(input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic re, input int ra);
        s_write_req  = we;
        s_write_addr = AW'(wa);
        s_write_data = wd;
        s_read_req   = re;
        s_read_addr  = AW'(ra);
        if (re) begin
            exp_q.push_back(model.exists(ra) ? model[ra] : 'x);
        end
        @(posedge clk);
        #1;
        if (we) begin
            model[wa] = wd;
        end
        s_write_req = 1'b0;
        s_read_req  = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        if (s_read_data !== 16'h0000) begin
            $display("FAIL reset_initial: got %h required %h", s_read_data, 16'h0000);
            n_err++;
        end
        n_cmp++;
        step(1'b1, 0, 16'h1234, 1'b0, 0);
        step(1'b0, 0, 16'h0000, 1'b1, 0);
        e = exp_q.pop_front();
        if (s_read_data !== e) begin
            $display("FAIL reset_preload: got %h required %h", s_read_data, e);
            n_err++;
        end
        n_cmp++;
        #2;
        reset = 1'b1;
        #1;
        if (s_read_data !== 16'h0000) begin
            $display("FAIL reset_async: got %h required %h", s_read_data, 16'h0000);
            n_err++;
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        if (s_read_data !== 16'h0000) begin
            $display("FAIL reset_hold: got %h required %h", s_read_data, 16'h0000);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] e;
        step(1'b1, 3, 16'hBEEF, 1'b0, 0);
        s_read_req  = 1'b1;
        s_read_addr = AW'(3);
        exp_q.push_back(model[3]);
        #3;
        if (s_read_data !== 16'h0000) begin
            $display("FAIL read_latency_early: got %h required %h", s_read_data, 16'h0000);
            n_err++;
        end
        n_cmp++;
        @(posedge clk);
        #1;
        s_read_req = 1'b0;
        e = exp_q.pop_front();
        if (s_read_data !== e || e !== 16'hBEEF) begin
            $display("FAIL write_read: got %h required %h", s_read_data, 16'hBEEF);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_hold();
        logic [DW-1:0] e;
        step(1'b0, 0, 16'h0000, 1'b1, 3);
        e = exp_q.pop_front();
        if (s_read_data !== e) begin
            $display("FAIL hold_read: got %h required %h", s_read_data, e);
            n_err++;
        end
        n_cmp++;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3, 16'h1111, 1'b0, 0);
            if (s_read_data !== 16'hBEEF) begin
                $display("FAIL hold_cycle%0d: got %h required %h", i, s_read_data, 16'hBEEF);
                n_err++;
            end
            n_cmp++;
        end
        step(1'b0, 0, 16'h0000, 1'b1, 3);
        e = exp_q.pop_front();
        if (s_read_data !== e) begin
            $display("FAIL hold_after_write: got %h required %h", s_read_data, e);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_collision();
        logic [DW-1:0] e;
        step(1'b1, 7, 16'h00AA, 1'b0, 0);
        step(1'b1, 7, 16'h0055, 1'b1, 7);
        e = exp_q.pop_front();
        if (s_read_data !== e || e !== 16'h00AA) begin
            $display("FAIL collision_old: got %h required %h", s_read_data, 16'h00AA);
            n_err++;
        end
        n_cmp++;
        step(1'b0, 0, 16'h0000, 1'b1, 7);
        e = exp_q.pop_front();
        if (s_read_data !== e || e !== 16'h0055) begin
            $display("FAIL collision_new: got %h required %h", s_read_data, 16'h0055);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_sweep();
        logic [DW-1:0] e;
        logic [DW-1:0] w;
        int bad;
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            w = DW'(a) ^ 16'h5A5A;
            step(1'b1, a, w, 1'b0, 0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 0, 16'h0000, 1'b1, a);
            e = exp_q.pop_front();
            if (s_read_data !== e) begin
                if (bad < 8) begin
                    $display("FAIL sweep_addr%0d: got %h required %h", a, s_read_data, e);
                end
                bad++;
                n_err++;
            end
            n_cmp++;
        end
        if (s_read_data !== (16'(DEPTH - 1) ^ 16'h5A5A)) begin
            $display("FAIL sweep_top: got %h required %h", s_read_data,
                     16'(DEPTH - 1) ^ 16'h5A5A);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int ra [6] = '{0, 1, 2, 0, 1, 2};
        int wa [6] = '{4, 5, 4, 5, 4, 5};
        logic [DW-1:0] wd [6] = '{16'hC004, 16'hC005, 16'hD004, 16'hD005, 16'hE004, 16'hE005};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, wa[i], wd[i], 1'b1, ra[i]);
            e = exp_q.pop_front();
            if (s_read_data !== e) begin
                $display("FAIL b2b_read%0d: got %h required %h", i, s_read_data, e);
                n_err++;
            end
            n_cmp++;
        end
        step(1'b0, 0, 16'h0000, 1'b1, 4);
        e = exp_q.pop_front();
        if (s_read_data !== e || e !== 16'hE004) begin
            $display("FAIL b2b_write4: got %h required %h", s_read_data, 16'hE004);
            n_err++;
        end
        n_cmp++;
        step(1'b0, 0, 16'h0000, 1'b1, 5);
        e = exp_q.pop_front();
        if (s_read_data !== e || e !== 16'hE005) begin
            $display("FAIL b2b_write5: got %h required %h", s_read_data, 16'hE005);
            n_err++;
        end
        n_cmp++;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        s_write_req  = 1'b0;
        s_write_addr = '0;
        s_write_data = '0;
        s_read_req   = 1'b0;
        s_read_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_hold();
        test_collision();
        test_sweep();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
            n_err++;
        end
        n_cmp++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
